sc_scbc_ulpi_seq: RTL and testbench

//  Power-up/reset sequencer for the external ULPI PHY, sitting between the GSR control bits and the PHY pins.

---
 rtl/sc_scbc_reg_pkg.sv | 22 ++
 rtl/sc_scbc_ulpi_seq_if.sv | 24 ++
 rtl/sc_scbc_sync.sv | 23 ++
 rtl/sc_scbc_ulpi_seq.sv | 129 ++++++++++++
 tb/tb_sc_scbc_ulpi_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_scbc_reg_pkg.sv
// Shared GSR/sequencer types: ULPI sequencer state encoding and pin decode.
package sc_scbc_reg_pkg;

    typedef enum logic [2:0] {
        OFF        = 3'd0,
        PWR_SETTLE = 3'd1,
        RST_PULSE  = 3'd2,
        WAIT_CLK   = 3'd3,
        READY      = 3'd4,
        ERROR      = 3'd5
    } scbcUlpiSeqState_t;

    // {PWRDWNB, RSTB} driven to the PHY in each state
    function automatic logic [1:0] seq_pins(scbcUlpiSeqState_t s);
        case (s)
            PWR_SETTLE, RST_PULSE: seq_pins = 2'b10;
            WAIT_CLK, READY:       seq_pins = 2'b11;
            default:               seq_pins = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sc_scbc_ulpi_seq_if.sv
// GSR-side control/status bundle of the ULPI sequencer.
interface sc_scbc_ulpi_seq_if;
    import sc_scbc_reg_pkg::*;

    logic              START_REQ;
    logic              STOP_REQ;
    logic              SRST_REQ;
    scbcUlpiSeqState_t SEQ_STATE;
    logic              PHY_READY;
    logic              SEQ_BUSY;
    logic              ERR_TIMEOUT;
    logic              ERR_CLKLOST;
    logic              SEQ_EVENT;

    modport master (
        output START_REQ, STOP_REQ, SRST_REQ,
        input  SEQ_STATE, PHY_READY, SEQ_BUSY, ERR_TIMEOUT, ERR_CLKLOST, SEQ_EVENT
    );

    modport slave (
        input  START_REQ, STOP_REQ, SRST_REQ,
        output SEQ_STATE, PHY_READY, SEQ_BUSY, ERR_TIMEOUT, ERR_CLKLOST, SEQ_EVENT
    );
endinterface

// File: rtl/sc_scbc_sync.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module sc_scbc_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sc_scbc_ulpi_seq.sv
// ULPI PHY power-up/reset sequencer: turns GSR requests into timed PWRDWNB/RSTB
// sequences, waits for the PHY clock and reports timeout/clock-loss errors.
module sc_scbc_ulpi_seq
    import sc_scbc_reg_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned PWR_CYCLES  = 1000,
    parameter int unsigned RST_CYCLES  = 100,
    parameter int unsigned CLK_TIMEOUT = 50000
) (
    input  logic              SYSCLK,
    input  logic              SYSRSTB,
    input  logic              ULPI_CLKSTATE,
    output logic              ULPI_PWRDWNB,
    output logic              ULPI_RSTB,
    sc_scbc_ulpi_seq_if.slave gsr
);

    localparam logic [CNT_WIDTH-1:0] PWR_LOAD = CNT_WIDTH'(PWR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RST_LOAD = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CLK_LOAD = CNT_WIDTH'(CLK_TIMEOUT - 1);

    scbcUlpiSeqState_t    state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_to_d, err_cl_d, event_d;
    logic [1:0]           pins_d;
    logic                 clk_s;

    sc_scbc_sync #(.WIDTH(1)) u_sync (
        .clk   (SYSCLK),
        .rst_n (SYSRSTB),
        .d     (ULPI_CLKSTATE),
        .q     (clk_s)
    );

    assign gsr.SEQ_STATE = state_q;

    // State, counter, sticky flags and pins, all taken from next-state values
    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB) begin
            state_q         <= OFF;
            cnt_q           <= '0;
            ULPI_PWRDWNB    <= 1'b0;
            ULPI_RSTB       <= 1'b0;
            gsr.PHY_READY   <= 1'b0;
            gsr.SEQ_BUSY    <= 1'b0;
            gsr.ERR_TIMEOUT <= 1'b0;
            gsr.ERR_CLKLOST <= 1'b0;
            gsr.SEQ_EVENT   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ULPI_PWRDWNB    <= pins_d[1];
            ULPI_RSTB       <= pins_d[0];
            gsr.PHY_READY   <= (state_d == READY);
            gsr.SEQ_BUSY    <= (state_d == PWR_SETTLE) || (state_d == RST_PULSE) ||
                               (state_d == WAIT_CLK);
            gsr.ERR_TIMEOUT <= err_to_d;
            gsr.ERR_CLKLOST <= err_cl_d;
            gsr.SEQ_EVENT   <= event_d;
        end
    end

    // Next state; STOP wins everything, clock presence wins over timeout/soft reset
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CNT_WIDTH'(1);
        err_to_d = gsr.ERR_TIMEOUT;
        err_cl_d = gsr.ERR_CLKLOST;
        event_d  = 1'b0;

        if (gsr.STOP_REQ) begin
            state_d  = OFF;
            cnt_d    = '0;
            err_to_d = 1'b0;
            err_cl_d = 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (gsr.START_REQ) begin
                        state_d = PWR_SETTLE;
                        cnt_d   = PWR_LOAD;
                    end
                end
                PWR_SETTLE, RST_PULSE: begin
                    if (cnt_q == '0) begin
                        state_d = WAIT_CLK;
                        cnt_d   = CLK_LOAD;
                    end
                end
                WAIT_CLK: begin
                    if (clk_s) begin
                        state_d = READY;
                        event_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d  = ERROR;
                        err_to_d = 1'b1;
                        event_d  = 1'b1;
                    end
                end
                READY: begin
                    if (!clk_s) begin
                        state_d  = ERROR;
                        err_cl_d = 1'b1;
                        event_d  = 1'b1;
                    end else if (gsr.SRST_REQ) begin
                        state_d = RST_PULSE;
                        cnt_d   = RST_LOAD;
                    end
                end
                ERROR: begin
                    if (gsr.START_REQ) begin
                        state_d  = PWR_SETTLE;
                        cnt_d    = PWR_LOAD;
                        err_to_d = 1'b0;
                        err_cl_d = 1'b0;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        pins_d = seq_pins(state_d);
    end

endmodule

// File: tb/tb_sc_scbc_ulpi_seq.sv
// Randomised bench for sc_scbc_ulpi_seq: expected READY/ERROR events are queued
// at stimulus time and matched by a monitor against every SEQ_EVENT pulse.
module tb_sc_scbc_ulpi_seq;
    import sc_scbc_reg_pkg::*;

    localparam int PWR = 8;
    localparam int RST = 4;
    localparam int TMO = 16;

    typedef struct {
        int unsigned at;
        logic [2:0]  st;
        logic        pd;
        logic        rb;
        logic        eto;
        logic        ecl;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clkstate = 1'b0;
    logic        pwrdwnb, rstb;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    ev_t         evq[$];

    sc_scbc_ulpi_seq_if gsr();

    sc_scbc_ulpi_seq #(
        .CNT_WIDTH   (16),
        .PWR_CYCLES  (PWR),
        .RST_CYCLES  (RST),
        .CLK_TIMEOUT (TMO)
    ) dut (
        .SYSCLK        (clk),
        .SYSRSTB       (rst_n),
        .ULPI_CLKSTATE (clkstate),
        .ULPI_PWRDWNB  (pwrdwnb),
        .ULPI_RSTB     (rstb),
        .gsr           (gsr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {state, PWRDWNB, RSTB, BUSY, READY} from the state's documented pin table
    function automatic logic [31:0] status_of(logic [2:0] st, logic pd, logic rb);
        logic busy, rdy;
        busy = (st >= 3'd1) && (st <= 3'd3);
        rdy  = (st == 3'd4);
        return 32'({st, pd, rb, busy, rdy});
    endfunction

    function automatic logic [31:0] status_act();
        return 32'({gsr.SEQ_STATE, pwrdwnb, rstb, gsr.SEQ_BUSY, gsr.PHY_READY});
    endfunction

    task automatic check_status(input string name, input logic [2:0] st, input logic pd, input logic rb);
        check(name, status_act(), status_of(st, pd, rb));
    endtask

    task automatic check_flags(input string name, input logic eto, input logic ecl);
        check(name, 32'({gsr.ERR_TIMEOUT, gsr.ERR_CLKLOST}), 32'({eto, ecl}));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every SEQ_EVENT pulse must match the oldest expectation
    always @(negedge clk) begin
        if (gsr.SEQ_EVENT === 1'b1) begin
            if (evq.size() == 0) begin
                check("event_expected", 32'(evq.size()), 32'd1);
            end else begin
                ev_t e;
                e = evq.pop_front();
                check("event_cycle", cyc, e.at);
                check("event_status", status_act(), status_of(e.st, e.pd, e.rb));
                check("event_flags", 32'({gsr.ERR_TIMEOUT, gsr.ERR_CLKLOST}), 32'({e.eto, e.ecl}));
            end
        end
    end

    // START with CLKSTATE first sampled high 'rel' edges after the START edge
    task automatic power_up(input int rel, output bit ready);
        ev_t         e;
        int unsigned e0;
        clkstate = 1'b0;
        repeat (3) tick();
        e0    = cyc + 1;
        ready = (rel + 2 <= PWR + TMO);
        e.at  = ready ? e0 + 32'((rel + 2 > PWR + 1) ? rel + 2 : PWR + 1)
                      : e0 + 32'(PWR + TMO);
        e.st  = ready ? 3'd4 : 3'd5;
        e.pd  = ready;
        e.rb  = ready;
        e.eto = !ready;
        e.ecl = 1'b0;
        evq.push_back(e);
        for (int i = 0; i <= PWR + TMO; i++) begin
            gsr.START_REQ = (i == 0);
            clkstate      = (i >= rel);
            tick();
            if (i == 0) begin
                check_status("settle_entry", 3'd1, 1'b1, 1'b0);
                check_flags("settle_err_clear", 1'b0, 1'b0);
            end
            if (i == PWR - 1) check_status("settle_last", 3'd1, 1'b1, 1'b0);
            if (i == PWR)     check_status("wait_clk_entry", 3'd3, 1'b1, 1'b1);
        end
        gsr.START_REQ = 1'b0;
        if (ready) check_status("ready_hold", 3'd4, 1'b1, 1'b1);
        else       check_status("timeout_error", 3'd5, 1'b0, 1'b0);
        check_flags("after_power_up", !ready, 1'b0);
    endtask

    task automatic soft_reset();
        ev_t e;
        e.at = cyc + 1 + 32'(RST + 1);
        e.st = 3'd4; e.pd = 1'b1; e.rb = 1'b1; e.eto = 1'b0; e.ecl = 1'b0;
        evq.push_back(e);
        for (int i = 0; i <= RST + 1; i++) begin
            gsr.SRST_REQ = (i == 0);
            tick();
            if (i < RST)       check_status("rst_pulse", 3'd2, 1'b1, 1'b0);
            else if (i == RST) check_status("rst_wait_clk", 3'd3, 1'b1, 1'b1);
        end
        gsr.SRST_REQ = 1'b0;
        check_status("rst_back_ready", 3'd4, 1'b1, 1'b1);
    endtask

    task automatic clock_loss();
        ev_t e;
        e.at = cyc + 1 + 32'd2;
        e.st = 3'd5; e.pd = 1'b0; e.rb = 1'b0; e.eto = 1'b0; e.ecl = 1'b1;
        evq.push_back(e);
        clkstate = 1'b0;
        for (int i = 0; i <= 2; i++) begin
            tick();
            if (i < 2) check_status("ready_until_loss", 3'd4, 1'b1, 1'b1);
        end
        check_flags("clklost_flag", 1'b0, 1'b1);
    endtask

    task automatic stop();
        gsr.STOP_REQ  = 1'b1;
        gsr.START_REQ = 1'($urandom_range(0, 1));
        gsr.SRST_REQ  = 1'($urandom_range(0, 1));
        tick();
        gsr.STOP_REQ  = 1'b0;
        gsr.START_REQ = 1'b0;
        gsr.SRST_REQ  = 1'b0;
        check_status("stop_off", 3'd0, 1'b0, 1'b0);
        check_flags("stop_err_clear", 1'b0, 1'b0);
    endtask

    initial begin
        bit ready;
        gsr.START_REQ = 1'b0;
        gsr.STOP_REQ  = 1'b0;
        gsr.SRST_REQ  = 1'b0;
        repeat (2) tick();
        check_status("reset_status", 3'd0, 1'b0, 1'b0);
        check_flags("reset_flags", 1'b0, 1'b0);
        check("reset_event", 32'(gsr.SEQ_EVENT), 32'd0);
        rst_n = 1'b1;
        tick();

        // Priority and ignored requests in OFF
        gsr.START_REQ = 1'b1; gsr.STOP_REQ = 1'b1;
        tick();
        gsr.START_REQ = 1'b0; gsr.STOP_REQ = 1'b0;
        check_status("start_stop_off", 3'd0, 1'b0, 1'b0);
        gsr.SRST_REQ = 1'b1;
        tick();
        gsr.SRST_REQ = 1'b0;
        check_status("srst_in_off", 3'd0, 1'b0, 1'b0);

        // STOP during PWR_SETTLE
        gsr.START_REQ = 1'b1;
        tick();
        gsr.START_REQ = 1'b0;
        repeat (2) tick();
        check_status("settle_mid", 3'd1, 1'b1, 1'b0);
        stop();

        // Directed: power-up, soft reset, ignored START, clock loss, retry
        power_up(0, ready);
        soft_reset();
        gsr.START_REQ = 1'b1;
        tick();
        gsr.START_REQ = 1'b0;
        check_status("start_in_ready", 3'd4, 1'b1, 1'b1);
        clock_loss();
        power_up(5, ready);
        stop();

        // Boundary: clock on the last WAIT_CLK cycle, then one cycle too late
        power_up(22, ready);
        stop();
        power_up(23, ready);
        stop();

        for (int t = 0; t < 10; t++) begin
            power_up(int'($urandom_range(0, 26)), ready);
            if (ready) begin
                if ($urandom_range(0, 1) == 0) soft_reset();
                else                            clock_loss();
            end
            stop();
        end

        // Reset asserted mid WAIT_CLK: reset values next edge, no event
        clkstate = 1'b0;
        repeat (3) tick();
        gsr.START_REQ = 1'b1;
        tick();
        gsr.START_REQ = 1'b0;
        repeat (PWR + 2) tick();
        check_status("pre_reset_wait_clk", 3'd3, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        check_status("mid_reset_status", 3'd0, 1'b0, 1'b0);
        check_flags("mid_reset_flags", 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (TMO + 4) tick();
        check_status("post_reset_idle", 3'd0, 1'b0, 1'b0);

        check("events_drained", 32'(evq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
